// File: rtl/n1_ir_if.sv
// Flow-control <-> instruction-register bus: program-bus data and fc2ir strobes
// one way, registered ir2fc decode flags the other.
interface n1_ir_if #(
    parameter int PBUS_DW = 16
) ();
    logic [PBUS_DW-1:0] pbus_dat;
    logic               fc2ir_capture;
    logic               fc2ir_stash;
    logic               fc2ir_expend;
    logic               fc2ir_force_eow;
    logic               fc2ir_force_0call;
    logic               fc2ir_force_call;
    logic               fc2ir_force_drop;
    logic               fc2ir_force_nop;
    logic               ir2fc_eow;
    logic               ir2fc_eow_postpone;
    logic               ir2fc_jump_or_call;
    logic               ir2fc_bra;
    logic               ir2fc_scyc;
    logic               ir2fc_mem;
    logic               ir2fc_mem_rd;
    logic               ir2fc_madr_sel;

    modport master (
        output pbus_dat, fc2ir_capture, fc2ir_stash, fc2ir_expend, fc2ir_force_eow,
               fc2ir_force_0call, fc2ir_force_call, fc2ir_force_drop, fc2ir_force_nop,
        input  ir2fc_eow, ir2fc_eow_postpone, ir2fc_jump_or_call, ir2fc_bra,
               ir2fc_scyc, ir2fc_mem, ir2fc_mem_rd, ir2fc_madr_sel
    );

    modport slave (
        input  pbus_dat, fc2ir_capture, fc2ir_stash, fc2ir_expend, fc2ir_force_eow,
               fc2ir_force_0call, fc2ir_force_call, fc2ir_force_drop, fc2ir_force_nop,
        output ir2fc_eow, ir2fc_eow_postpone, ir2fc_jump_or_call, ir2fc_bra,
               ir2fc_scyc, ir2fc_mem, ir2fc_mem_rd, ir2fc_madr_sel
    );
endinterface

// File: rtl/n1_ir.sv
// Instruction register stage: current IR, one stash IR, forced instructions and
// registered decode flags. Optional illegal-opcode trap under N1_IR_ILLOP_EN.
module n1_ir #(
    parameter int          PBUS_DW  = 16,
    parameter logic [15:0] NOP_OPC  = 16'h0000,
    parameter logic [15:0] DROP_OPC = 16'h0102,
    parameter logic [14:0] ISR_VEC  = 15'h0010
) (
    input  logic               clk_i,
    input  logic               sync_rst_i,
    n1_ir_if.slave             ir_bus,
    output logic [PBUS_DW-1:0] ir_opc_o,
    output logic               ir_stash_vld_o,
    output logic               ir2excpt_illop_o,
    output logic [PBUS_DW-1:0] prb_ir_stash_o
);

    typedef struct packed {
        logic eow;
        logic eow_postpone;
        logic jump_or_call;
        logic bra;
        logic scyc;
        logic mem;
        logic mem_rd;
        logic madr_sel;
    } flags_t;

    function automatic flags_t decode(input logic [15:0] w);
        flags_t f;
        logic   mem, alu, lit, call, jmp;
        call           = w[15];
        jmp            = (w[15:14] == 2'b01) && !w[13];
        lit            = (w[15:13] == 3'b001);
        mem            = (w[15:12] == 4'b0001);
        alu            = (w[15:12] == 4'b0000);
        f.eow          = (mem || alu) && w[0];
        f.eow_postpone = mem && w[0];
        f.jump_or_call = call || jmp;
        f.bra          = (w[15:14] == 2'b01) && w[13];
        f.scyc         = lit || alu;
        f.mem          = mem;
        f.mem_rd       = mem && w[11];
        f.madr_sel     = mem && w[10];
        return f;
    endfunction

    logic [15:0] r_ir;
    logic [15:0] r_stash;
    logic        r_stash_vld;
    flags_t      r_flags;

    logic [15:0] w_ir_nxt;
    logic [15:0] w_stash_nxt;
    logic        w_stash_vld_nxt;
    logic        w_any_force;
    logic        w_from_bus;
    logic        w_illop_nxt;
    flags_t      w_flags_nxt;

    assign w_any_force = ir_bus.fc2ir_force_0call | ir_bus.fc2ir_force_call |
                         ir_bus.fc2ir_force_drop  | ir_bus.fc2ir_force_nop;

    always_comb begin
        w_ir_nxt        = r_ir;
        w_stash_nxt     = r_stash;
        w_stash_vld_nxt = r_stash_vld;
        w_from_bus      = 1'b0;
        w_illop_nxt     = 1'b0;

        if (ir_bus.fc2ir_force_0call) begin
            w_ir_nxt = 16'h8000;
        end else if (ir_bus.fc2ir_force_call) begin
            w_ir_nxt = {1'b1, ISR_VEC};
        end else if (ir_bus.fc2ir_force_drop) begin
            w_ir_nxt = DROP_OPC;
        end else if (ir_bus.fc2ir_force_nop) begin
            w_ir_nxt = NOP_OPC;
        end else if (ir_bus.fc2ir_expend) begin
            // An empty stash expends as a NOP rather than replaying stale data
            if (r_stash_vld) begin
                w_ir_nxt   = r_stash;
                w_from_bus = 1'b1;
            end else begin
                w_ir_nxt = NOP_OPC;
            end
            w_stash_vld_nxt = 1'b0;
        end else if (ir_bus.fc2ir_capture) begin
            w_ir_nxt   = ir_bus.pbus_dat;
            w_from_bus = 1'b1;
        end

`ifdef N1_IR_ILLOP_EN
        if (w_from_bus && (w_ir_nxt[15:12] == 4'b0000) && (w_ir_nxt[11:8] == 4'b1111)) begin
            w_ir_nxt    = NOP_OPC;
            w_illop_nxt = 1'b1;
        end
`else
        w_illop_nxt = 1'b0 & w_from_bus;
`endif

        // EOW only exists for the ALU and memory classes
        if (ir_bus.fc2ir_force_eow && (w_ir_nxt[15:13] == 3'b000)) begin
            w_ir_nxt[0] = 1'b1;
        end

        if (ir_bus.fc2ir_stash) begin
            w_stash_nxt     = ir_bus.pbus_dat;
            w_stash_vld_nxt = 1'b1;
        end

        w_flags_nxt = decode(w_ir_nxt);
    end

`ifdef N1_IR_ILLOP_EN
    logic r_illop;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_illop <= 1'b0;
        end else begin
            r_illop <= w_illop_nxt;
        end
    end

    assign ir2excpt_illop_o = r_illop;
`else
    assign ir2excpt_illop_o = w_illop_nxt;
`endif

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            r_ir        <= NOP_OPC;
            r_stash     <= NOP_OPC;
            r_stash_vld <= 1'b0;
            r_flags     <= decode(NOP_OPC);
        end else begin
            r_ir        <= w_ir_nxt;
            r_stash     <= w_stash_nxt;
            r_stash_vld <= w_stash_vld_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

    assign ir_opc_o                  = r_ir;
    assign prb_ir_stash_o            = r_stash;
    assign ir_stash_vld_o            = r_stash_vld;
    assign ir_bus.ir2fc_eow          = r_flags.eow;
    assign ir_bus.ir2fc_eow_postpone = r_flags.eow_postpone;
    assign ir_bus.ir2fc_jump_or_call = r_flags.jump_or_call;
    assign ir_bus.ir2fc_bra          = r_flags.bra;
    assign ir_bus.ir2fc_scyc         = r_flags.scyc;
    assign ir_bus.ir2fc_mem          = r_flags.mem;
    assign ir_bus.ir2fc_mem_rd       = r_flags.mem_rd;
    assign ir_bus.ir2fc_madr_sel     = r_flags.madr_sel;

endmodule

// File: tb/tb_n1_ir.sv
// Directed bench for n1_ir: hand-computed vectors for reset, capture, stash,
// forced instructions, strobe priority and the optional illegal-opcode trap.
`timescale 1ns/1ps
module tb_n1_ir;

    logic        clk_i = 1'b0;
    logic        sync_rst_i;
    logic [15:0] ir_opc_o;
    logic        ir_stash_vld_o;
    logic        ir2excpt_illop_o;
    logic [15:0] prb_ir_stash_o;

    int n_tests = 0;
    int n_fail  = 0;

    n1_ir_if #(.PBUS_DW(16)) bus ();

    n1_ir dut (
        .clk_i            (clk_i),
        .sync_rst_i       (sync_rst_i),
        .ir_bus           (bus.slave),
        .ir_opc_o         (ir_opc_o),
        .ir_stash_vld_o   (ir_stash_vld_o),
        .ir2excpt_illop_o (ir2excpt_illop_o),
        .prb_ir_stash_o   (prb_ir_stash_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pbus_dat          = 16'h0000;
        bus.fc2ir_capture     = 1'b0;
        bus.fc2ir_stash       = 1'b0;
        bus.fc2ir_expend      = 1'b0;
        bus.fc2ir_force_eow   = 1'b0;
        bus.fc2ir_force_0call = 1'b0;
        bus.fc2ir_force_call  = 1'b0;
        bus.fc2ir_force_drop  = 1'b0;
        bus.fc2ir_force_nop   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    // packed flags: eow, eow_postpone, jump_or_call, bra, scyc, mem, mem_rd, madr_sel
    function automatic logic [7:0] flags();
        return {bus.ir2fc_eow, bus.ir2fc_eow_postpone, bus.ir2fc_jump_or_call, bus.ir2fc_bra,
                bus.ir2fc_scyc, bus.ir2fc_mem, bus.ir2fc_mem_rd, bus.ir2fc_madr_sel};
    endfunction

    initial begin
        idle();
        sync_rst_i = 1'b0;
        #1;
        bus.fc2ir_capture = 1'b1;
        bus.pbus_dat      = 16'h8123;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        chk("rst_ir", ir_opc_o, 16'h0000);
        sync_rst_i = 1'b1;
        idle();
        step();
        chk("rst_ir_rel", ir_opc_o, 16'h0000);
        chk("rst_flags", flags(), 8'b0000_1000);
        chk("rst_vld", ir_stash_vld_o, 1'b0);
        chk("rst_stash", prb_ir_stash_o, 16'h0000);
        chk("rst_illop", ir2excpt_illop_o, 1'b0);

        bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h1C01; step();
        chk("cap_ir", ir_opc_o, 16'h1C01);
        chk("cap_flags", flags(), 8'b1100_0111);

        bus.fc2ir_stash = 1'b1; bus.pbus_dat = 16'h4005; step();
        chk("stash_vld", ir_stash_vld_o, 1'b1);
        chk("stash_prb", prb_ir_stash_o, 16'h4005);
        chk("stash_ir_hold", ir_opc_o, 16'h1C01);
        bus.fc2ir_expend = 1'b1; step();
        chk("exp_ir", ir_opc_o, 16'h4005);
        chk("exp_flags", flags(), 8'b0010_0000);
        chk("exp_vld", ir_stash_vld_o, 1'b0);
        bus.fc2ir_expend = 1'b1; step();
        chk("exp_empty_ir", ir_opc_o, 16'h0000);
        chk("exp_empty_stash", prb_ir_stash_o, 16'h4005);

        bus.fc2ir_stash = 1'b1; bus.pbus_dat = 16'h3005; step();
        bus.fc2ir_force_call = 1'b1; bus.fc2ir_expend = 1'b1;
        bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h1C01; step();
        chk("fcall_ir", ir_opc_o, 16'h8010);
        chk("fcall_vld", ir_stash_vld_o, 1'b1);
        chk("fcall_stash", prb_ir_stash_o, 16'h3005);
        chk("fcall_flags", flags(), 8'b0010_0000);
        bus.fc2ir_force_eow = 1'b1; step();
        chk("feow_call_ir", ir_opc_o, 16'h8010);
        chk("feow_call_eow", bus.ir2fc_eow, 1'b0);

        bus.fc2ir_expend = 1'b1; step();
        chk("exp_lit_ir", ir_opc_o, 16'h3005);
        bus.fc2ir_stash = 1'b1; bus.pbus_dat = 16'h2001; step();
        bus.fc2ir_stash = 1'b1; bus.fc2ir_expend = 1'b1; bus.pbus_dat = 16'h0002; step();
        chk("sx_ir", ir_opc_o, 16'h2001);
        chk("sx_stash", prb_ir_stash_o, 16'h0002);
        chk("sx_vld", ir_stash_vld_o, 1'b1);
        chk("sx_flags", flags(), 8'b0000_1000);

        bus.fc2ir_force_drop = 1'b1; bus.fc2ir_force_nop = 1'b1; step();
        chk("fdrop_ir", ir_opc_o, 16'h0102);
        bus.fc2ir_force_nop = 1'b1; bus.fc2ir_force_eow = 1'b1; step();
        chk("fnop_eow_ir", ir_opc_o, 16'h0001);
        chk("fnop_eow_flags", flags(), 8'b1000_1000);
        bus.fc2ir_force_0call = 1'b1; bus.fc2ir_force_call = 1'b1; step();
        chk("f0call_ir", ir_opc_o, 16'h8000);
        bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h6003; step();
        chk("bra_flags", flags(), 8'b0001_0000);
        bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h1400; bus.fc2ir_force_eow = 1'b1; step();
        chk("mem_wr_ir", ir_opc_o, 16'h1401);
        chk("mem_wr_flags", flags(), 8'b1100_0101);

        bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h0F00; step();
`ifdef N1_IR_ILLOP_EN
        chk("illop_ir", ir_opc_o, 16'h0000);
        chk("illop_pulse", ir2excpt_illop_o, 1'b1);
`else
        chk("illop_ir", ir_opc_o, 16'h0F00);
        chk("illop_pulse", ir2excpt_illop_o, 1'b0);
`endif
        step();
        chk("illop_clear", ir2excpt_illop_o, 1'b0);

        bus.fc2ir_stash = 1'b1; bus.pbus_dat = 16'h4444; step();
        sync_rst_i = 1'b0;
        bus.fc2ir_stash = 1'b1; bus.fc2ir_capture = 1'b1; bus.pbus_dat = 16'h1C01;
        @(posedge clk_i);
        #1;
        sync_rst_i = 1'b1;
        idle();
        chk("midrst_ir", ir_opc_o, 16'h0000);
        chk("midrst_vld", ir_stash_vld_o, 1'b0);
        chk("midrst_stash", prb_ir_stash_o, 16'h0000);
        chk("midrst_flags", flags(), 8'b0000_1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/n1_ir.md
Name: n1_ir

Overview:
- Instruction register stage directly downstream of the flow-control FSM.
- Captures program-bus read data under fc2ir_* control and holds the current instruction plus one stashed instruction.
- Applies forced instructions (EOW, 0-CALL, CALL, DROP, NOP).
- Returns registered decode flags (ir2fc_*) to the flow-control FSM and opcode fields to the datapath.

Parameters:
- PBUS_DW, 16, program-bus/instruction width (fixed encoding requires 16)
- NOP_OPC, 16'h0000, encoding loaded by force_nop and at reset
- DROP_OPC, 16'h0102, encoding loaded by force_drop
- ISR_VEC, 15'h0010, target address of the forced CALL

Ports:
- clk_i in 1: module clock
- sync_rst_i in 1: synchronous reset, active-low
- pbus_dat_i in 16: program-bus read data
- fc2ir_capture_i in 1: pbus_dat_i -> current IR
- fc2ir_stash_i in 1: pbus_dat_i -> stash IR
- fc2ir_expend_i in 1: stash IR -> current IR
- fc2ir_force_eow_i in 1: set EOW bit of current IR
- fc2ir_force_0call_i in 1: load CALL 0 (16'h8000)
- fc2ir_force_call_i in 1: load CALL ISR_VEC
- fc2ir_force_drop_i in 1: load DROP_OPC
- fc2ir_force_nop_i in 1: load NOP_OPC
- ir2fc_eow_o out 1: EOW bit set
- ir2fc_eow_postpone_o out 1: EOW on memory instruction
- ir2fc_jump_or_call_o out 1: JUMP or CALL
- ir2fc_bra_o out 1: conditional BRANCH
- ir2fc_scyc_o out 1: single-cycle linear instruction
- ir2fc_mem_o out 1: memory I/O
- ir2fc_mem_rd_o out 1: memory read
- ir2fc_madr_sel_o out 1: direct memory address
- ir_opc_o out 16: current IR contents
- ir_stash_vld_o out 1: stash holds an unexpended instruction
- ir2excpt_illop_o out 1: illegal-opcode pulse (optional feature only)
- prb_ir_stash_o out 16: stash IR probe

Behaviour:
- Encoding:
  - [15]=1: CALL [14:0]
  - [15:14]=01: [13]=1 BRANCH, else JUMP; offset [12:0]
  - [15:13]=001: literal
  - [15:12]=0001: memory; [11]=rd, [10]=direct address, [0]=EOW
  - [15:12]=0000: ALU/stack; [0]=EOW
- Decode flags:
  - eow = [0] for classes 0000/0001, else 0
  - eow_postpone = eow & mem
  - scyc = literal | ALU class
  - jump_or_call = CALL | JUMP
- All flags are registered: they are computed from the next-IR value at load, so they are valid in the same cycle as ir_opc_o. Latency is one clock from control strobe to updated IR and flags.
- Current-IR priority when several strobes are set: force_0call > force_call > force_drop > force_nop > expend > capture > hold.
- force_eow ORs bit0 into whatever is loaded that cycle, or into the held IR. It is ignored for CALL/JUMP/BRANCH/literal classes (eow stays 0).
- Stash register:
  - stash_i loads pbus_dat_i and sets stash_vld.
  - expend clears stash_vld.
  - stash_i and expend in the same cycle: current <- old stash, stash <- pbus_dat_i, stash_vld stays 1.
  - stash_i and capture in the same cycle: both registers load pbus_dat_i.
- expend with stash_vld=0: current IR <- NOP_OPC, stash unchanged.
- Any force strobe with expend: force wins, stash is NOT consumed and stash_vld keeps its value.
- Reset (sync_rst_i=0 at clock edge) overrides every strobe, including mid-sequence:
  - current IR = NOP_OPC, stash = NOP_OPC, stash_vld = 0
  - flags as decoded from NOP_OPC: scyc=1, all others 0
  - ir2excpt_illop_o = 0

Optional Feature:
- Macro: N1_IR_ILLOP_EN.
- With the macro: an ALU-class word with [11:8]=4'b1111 arriving via capture or expend is replaced by NOP_OPC, and ir2excpt_illop_o pulses high for exactly one cycle, aligned with the NOP load.
- Without the macro: the word loads unchanged and ir2excpt_illop_o is tied to 0.

Test Plan:
- Reset: hold sync_rst_i=0 for 2 clocks with capture=1, pbus_dat_i=16'h8123 -> ir_opc_o=16'h0000, scyc=1, stash_vld=0 after release.
- Capture: capture with pbus_dat_i=16'h1C01 -> next cycle mem=1, mem_rd=1, madr_sel=1, eow=1, eow_postpone=1, scyc=0.
- Stash/expend:
  - stash 16'h4005, then expend -> ir_opc_o=16'h4005, jump_or_call=1, stash_vld=0.
  - A second expend -> ir_opc_o=16'h0000.
- Simultaneous strobes:
  - force_call + expend + capture with stash_vld=1 -> ir_opc_o=16'h8010, stash_vld remains 1.
  - Next cycle force_eow alone -> eow stays 0.
- Stash+expend same cycle: stash=16'h2001 valid, pbus_dat_i=16'h0002 -> ir_opc_o=16'h2001, prb_ir_stash_o=16'h0002, stash_vld=1.
- Illegal opcode: capture 16'h0F00 -> with N1_IR_ILLOP_EN, ir_opc_o=16'h0000 and illop high one cycle; without it, ir_opc_o=16'h0F00 and illop=0.
